// File: rtl/uno_seq.sv
// Upstream sequencer for the uno PE: request capture, per-cycle issue control,
// coefficient table and result return. Define UNO_SEQ_PERF_EN to add perf counters.
module uno_seq #(
    parameter int MAC_BW  = 12,
    parameter int TERMS   = 4,
    parameter int MAC_LAT = 1,
    parameter int IDX_W   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [MAC_BW-1:0]     req_x,
    input  logic [MAC_BW-1:0]     req_y,
    input  logic [2*MAC_BW-1:0]   req_z,
    input  logic                  req_acc,
    input  logic                  cfg_we,
    input  logic [1:0]            cfg_op,
    input  logic [IDX_W-1:0]      cfg_idx,
    input  logic [MAC_BW-1:0]     cfg_data,
    output logic                  cfg_ready,
    output logic [1:0]            uno_op,
    output logic [MAC_BW-1:0]     uno_x,
    output logic [MAC_BW-1:0]     uno_y,
    output logic [2*MAC_BW-1:0]   uno_z,
    output logic [MAC_BW-1:0]     uno_coeff,
    output logic                  uno_first_cycle,
    output logic                  uno_last_cycle,
    output logic                  uno_acc_en,
    output logic                  uno_issue,
    input  logic [2*MAC_BW-1:0]   mac_o,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [2*MAC_BW-1:0]   res_data,
    output logic [1:0]            res_op
`ifdef UNO_SEQ_PERF_EN
    ,
    output logic [31:0]           perf_ops,
    output logic [31:0]           perf_busy
`endif
);

    localparam int TAB_D = 4 * (2 ** IDX_W);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                state_r, state_s;
    logic [IDX_W-1:0]      cnt_r, cnt_s, cnt_inc_s;
    logic [1:0]            dcnt_r, dcnt_s;
    logic [1:0]            op_r, op_s;
    logic [MAC_BW-1:0]     x_r, x_s, y_r, y_s;
    logic [2*MAC_BW-1:0]   z_r, z_s;
    logic                  acc_r, acc_s;
    logic [MAC_BW-1:0]     coeff_r, coeff_s, coeff_first_s, coeff_next_s;
    logic                  first_r, first_s, last_r, last_s;
    logic                  acc_en_r, acc_en_s, issue_r, issue_s;
    logic                  res_valid_r, res_valid_s;
    logic [2*MAC_BW-1:0]   res_data_r, res_data_s;
    logic [1:0]            res_op_r, res_op_s;
    logic                  req_ready_r, req_ready_s, cfg_ready_r, cfg_ready_s;
    logic                  wr_en_s;
    logic [MAC_BW-1:0]     tab_r [0:TAB_D-1];

    // Coefficient table write qualification and lookups; a same-cycle write is forwarded.
    always_comb begin
        wr_en_s   = cfg_we && cfg_ready_r && ({1'b0, cfg_idx} < (IDX_W+1)'(TERMS));
        cnt_inc_s = cnt_r + IDX_W'(1);
        if (wr_en_s && (cfg_op == req_op) && (cfg_idx == '0)) begin
            coeff_first_s = cfg_data;
        end else begin
            coeff_first_s = tab_r[{req_op, {IDX_W{1'b0}}}];
        end
        coeff_next_s = tab_r[{op_r, cnt_inc_s}];
    end

    // Next-state and next-output logic; all outputs are registered from these values.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        dcnt_s      = dcnt_r;
        op_s        = op_r;
        x_s         = x_r;
        y_s         = y_r;
        z_s         = z_r;
        acc_s       = acc_r;
        coeff_s     = '0;
        first_s     = 1'b0;
        last_s      = 1'b0;
        acc_en_s    = 1'b0;
        issue_s     = 1'b0;
        res_valid_s = res_valid_r;
        res_data_s  = res_data_r;
        res_op_s    = res_op_r;
        req_ready_s = 1'b0;
        cfg_ready_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    state_s  = ISSUE;
                    cnt_s    = '0;
                    op_s     = req_op;
                    x_s      = req_x;
                    y_s      = req_y;
                    z_s      = req_z;
                    acc_s    = req_acc;
                    coeff_s  = coeff_first_s;
                    first_s  = 1'b1;
                    last_s   = (req_op == 2'b00);
                    acc_en_s = (req_op == 2'b00) && req_acc;
                    issue_s  = 1'b1;
                end else begin
                    req_ready_s = 1'b1;
                    cfg_ready_s = 1'b1;
                end
            end
            ISSUE: begin
                if (last_r) begin
                    state_s = DRAIN;
                    dcnt_s  = 2'(MAC_LAT - 1);
                end else begin
                    cnt_s   = cnt_inc_s;
                    coeff_s = coeff_next_s;
                    issue_s = 1'b1;
                    last_s  = (cnt_inc_s == IDX_W'(TERMS - 1));
                end
            end
            DRAIN: begin
                if (dcnt_r == 2'd0) begin
                    res_data_s  = mac_o;
                    res_op_s    = op_r;
                    res_valid_s = 1'b1;
                    state_s     = DONE;
                end else begin
                    dcnt_s = dcnt_r - 2'd1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    res_valid_s = 1'b0;
                    state_s     = IDLE;
                    req_ready_s = 1'b1;
                    cfg_ready_s = 1'b1;
                end else begin
                    res_valid_s = 1'b1;
                end
            end
            default: begin
                state_s     = IDLE;
                res_valid_s = 1'b0;
                req_ready_s = 1'b1;
                cfg_ready_s = 1'b1;
            end
        endcase
    end

    // State, operand and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            dcnt_r      <= 2'd0;
            op_r        <= 2'b00;
            x_r         <= '0;
            y_r         <= '0;
            z_r         <= '0;
            acc_r       <= 1'b0;
            coeff_r     <= '0;
            first_r     <= 1'b0;
            last_r      <= 1'b0;
            acc_en_r    <= 1'b0;
            issue_r     <= 1'b0;
            res_valid_r <= 1'b0;
            res_data_r  <= '0;
            res_op_r    <= 2'b00;
            req_ready_r <= 1'b1;
            cfg_ready_r <= 1'b1;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            dcnt_r      <= dcnt_s;
            op_r        <= op_s;
            x_r         <= x_s;
            y_r         <= y_s;
            z_r         <= z_s;
            acc_r       <= acc_s;
            coeff_r     <= coeff_s;
            first_r     <= first_s;
            last_r      <= last_s;
            acc_en_r    <= acc_en_s;
            issue_r     <= issue_s;
            res_valid_r <= res_valid_s;
            res_data_r  <= res_data_s;
            res_op_r    <= res_op_s;
            req_ready_r <= req_ready_s;
            cfg_ready_r <= cfg_ready_s;
        end
    end

    // Coefficient table storage, indexed by {op, idx}.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < TAB_D; i++) begin
                tab_r[i] <= '0;
            end
        end else if (wr_en_s) begin
            tab_r[{cfg_op, cfg_idx}] <= cfg_data;
        end else begin
            tab_r[{cfg_op, cfg_idx}] <= tab_r[{cfg_op, cfg_idx}];
        end
    end

`ifdef UNO_SEQ_PERF_EN
    logic [31:0] perf_ops_r, perf_busy_r;

    // Saturating completed-op and busy-cycle counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_ops_r  <= 32'd0;
            perf_busy_r <= 32'd0;
        end else begin
            if (res_valid_r && res_ready && (perf_ops_r != 32'hFFFF_FFFF)) begin
                perf_ops_r <= perf_ops_r + 32'd1;
            end
            if ((state_r != IDLE) && (perf_busy_r != 32'hFFFF_FFFF)) begin
                perf_busy_r <= perf_busy_r + 32'd1;
            end
        end
    end

    assign perf_ops  = perf_ops_r;
    assign perf_busy = perf_busy_r;
`endif

    assign req_ready       = req_ready_r;
    assign cfg_ready       = cfg_ready_r;
    assign uno_op          = op_r;
    assign uno_x           = x_r;
    assign uno_y           = y_r;
    assign uno_z           = z_r;
    assign uno_coeff       = coeff_r;
    assign uno_first_cycle = first_r;
    assign uno_last_cycle  = last_r;
    assign uno_acc_en      = acc_en_r;
    assign uno_issue       = issue_r;
    assign res_valid       = res_valid_r;
    assign res_data        = res_data_r;
    assign res_op          = res_op_r;

endmodule

// File: tb/tb_uno_seq.sv
// Scoreboard bench for uno_seq: directed requests push expected issue cycles and
// results into queues; negedge monitors pop and compare against the DUT.
module tb_uno_seq;

    localparam int BW = 12;
    localparam int TERMS = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0, req_ready, req_acc = 1'b0;
    logic [1:0]      req_op = 2'b00;
    logic [BW-1:0]   req_x = '0, req_y = '0;
    logic [2*BW-1:0] req_z = '0;
    logic            cfg_we = 1'b0, cfg_ready;
    logic [1:0]      cfg_op = 2'b00;
    logic [2:0]      cfg_idx = 3'd0;
    logic [BW-1:0]   cfg_data = '0;
    logic [1:0]      uno_op;
    logic [BW-1:0]   uno_x, uno_y, uno_coeff;
    logic [2*BW-1:0] uno_z, mac_o = '0;
    logic            uno_first_cycle, uno_last_cycle, uno_acc_en, uno_issue;
    logic            res_valid, res_ready = 1'b0;
    logic [2*BW-1:0] res_data;
    logic [1:0]      res_op;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [1:0]      op;
        logic [BW-1:0]   x;
        logic [BW-1:0]   y;
        logic [2*BW-1:0] z;
        logic [BW-1:0]   coeff;
        logic            first;
        logic            last;
        logic            acc_en;
    } issue_t;

    issue_t          issue_q[$];
    logic [25:0]     res_q[$];
    logic [BW-1:0]   tab[4][TERMS];

    uno_seq #(.MAC_BW(BW), .TERMS(TERMS), .MAC_LAT(1), .IDX_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_acc(req_acc),
        .cfg_we(cfg_we), .cfg_op(cfg_op), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready),
        .uno_op(uno_op), .uno_x(uno_x), .uno_y(uno_y), .uno_z(uno_z),
        .uno_coeff(uno_coeff), .uno_first_cycle(uno_first_cycle),
        .uno_last_cycle(uno_last_cycle), .uno_acc_en(uno_acc_en),
        .uno_issue(uno_issue), .mac_o(mac_o),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_op(res_op)
    );

    always #5 clk = ~clk;

    // PE stand-in with one cycle of latency; idle cycles produce a marker value.
    always @(posedge clk) begin
        if (uno_issue)
            mac_o <= 24'(uno_x) * 24'(uno_y) + uno_z + 24'(uno_coeff);
        else
            mac_o <= 24'hABCDEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    // Issue-cycle monitor.
    always @(negedge clk) begin
        if (rst_n && uno_issue) begin
            if (issue_q.size() == 0) begin
                chk("issue_unexpected", 32'(uno_issue), 32'd0);
            end else begin
                issue_t e;
                e = issue_q.pop_front();
                chk("issue_op", 32'(uno_op), 32'(e.op));
                chk("issue_xy", {8'd0, uno_x, uno_y}, {8'd0, e.x, e.y});
                chk("issue_z", 32'(uno_z), 32'(e.z));
                chk("issue_coeff", 32'(uno_coeff), 32'(e.coeff));
                chk("issue_flags", {29'd0, uno_first_cycle, uno_last_cycle, uno_acc_en},
                    {29'd0, e.first, e.last, e.acc_en});
            end
        end else if (rst_n) begin
            chk("idle_flags", {29'd0, uno_first_cycle, uno_last_cycle, uno_acc_en}, 32'd0);
        end
    end

    // Result monitor: pops on each result handshake.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (res_q.size() == 0) begin
                chk("res_unexpected", 32'(res_valid), 32'd0);
            end else begin
                logic [25:0] r;
                r = res_q.pop_front();
                chk("res_op", 32'(res_op), 32'(r[25:24]));
                chk("res_data", 32'(res_data), 32'(r[23:0]));
            end
        end
    end

    task automatic cfg_write(input logic [1:0] op, input logic [2:0] idx, input logic [BW-1:0] d);
        chk("cfg_ready_idle", 32'(cfg_ready), 32'd1);
        cfg_we = 1'b1; cfg_op = op; cfg_idx = idx; cfg_data = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        if (idx < 3'(TERMS)) tab[op][idx] = d;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [BW-1:0] x, input logic [BW-1:0] y,
                          input logic [2*BW-1:0] z, input logic acc, input int hold,
                          input bit busy_wr);
        int n;
        int cyc;
        logic [2*BW-1:0] expd;
        n = (op == 2'b00) ? 1 : TERMS;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        for (int k = 0; k < n; k++) begin
            issue_t e;
            e.op = op; e.x = x; e.y = y; e.z = z;
            e.coeff = tab[op][k];
            e.first = (k == 0);
            e.last = (k == n - 1);
            e.acc_en = (op == 2'b00) && acc;
            issue_q.push_back(e);
        end
        expd = 24'(x) * 24'(y) + z + 24'(tab[op][n-1]);
        res_q.push_back({op, expd});
        req_valid = 1'b1; req_op = op; req_x = x; req_y = y; req_z = z; req_acc = acc;
        @(posedge clk); #1;
        req_valid = 1'b0; req_x = ~x; req_y = ~y; req_z = ~z; req_acc = ~acc;
        cfg_we = 1'b0;
        cyc = 1;
        while (!res_valid && cyc < 50) begin
            if (busy_wr && cyc == 1) begin
                chk("cfg_ready_busy", 32'(cfg_ready), 32'd0);
                cfg_we = 1'b1; cfg_op = op; cfg_idx = 3'd0; cfg_data = 12'd9;
            end else begin
                cfg_we = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        cfg_we = 1'b0;
        chk("latency", 32'(cyc), 32'(n + 2));
        for (int h = 0; h < hold; h++) begin
            chk("hold_data", 32'(res_data), 32'(expd));
            chk("hold_req_ready", {30'd0, req_ready, res_valid}, 32'd1);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("post_handshake", {30'd0, req_ready, res_valid}, 32'd2);
    endtask

    initial begin
        for (int o = 0; o < 4; o++)
            for (int i = 0; i < TERMS; i++) tab[o][i] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_ready", {30'd0, req_ready, cfg_ready}, 32'd3);
        chk("rst_outs", {29'd0, res_valid, uno_issue, uno_first_cycle}, 32'd0);
        chk("rst_data", 32'(res_data) | 32'(uno_coeff) | 32'(uno_x), 32'd0);

        run_op(2'b00, 12'd3, 12'd5, 24'd7, 1'b0, 0, 1'b0);
        run_op(2'b00, 12'd2, 12'd4, 24'd1, 1'b1, 1, 1'b0);

        for (int i = 0; i < TERMS; i++) cfg_write(2'b10, 3'(i), 12'(i + 1));
        cfg_write(2'b10, 3'd4, 12'd77);
        run_op(2'b10, 12'd10, 12'd11, 24'd100, 1'b0, 5, 1'b0);

        run_op(2'b10, 12'd1, 12'd1, 24'd0, 1'b0, 0, 1'b1);
        run_op(2'b10, 12'd2, 12'd3, 24'd4, 1'b0, 0, 1'b0);

        cfg_we = 1'b1; cfg_op = 2'b01; cfg_idx = 3'd0; cfg_data = 12'd5;
        tab[1][0] = 12'd5;
        run_op(2'b01, 12'd6, 12'd7, 24'd8, 1'b0, 0, 1'b0);

        for (int k = 0; k < TERMS; k++) begin
            issue_t e;
            e.op = 2'b11; e.x = 12'd9; e.y = 12'd9; e.z = 24'd9; e.coeff = '0;
            e.first = (k == 0); e.last = (k == TERMS - 1); e.acc_en = 1'b0;
            issue_q.push_back(e);
        end
        req_valid = 1'b1; req_op = 2'b11; req_x = 12'd9; req_y = 12'd9; req_z = 24'd9;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue_q.delete();
        res_q.delete();
        chk("midrst_state", {29'd0, res_valid, req_ready, uno_issue}, 32'd2);
        for (int o = 0; o < 4; o++)
            for (int i = 0; i < TERMS; i++) tab[o][i] = '0;
        run_op(2'b10, 12'd1, 12'd2, 24'd3, 1'b0, 0, 1'b0);
        run_op(2'b01, 12'd4, 12'd5, 24'd6, 1'b0, 0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk("queues_empty", 32'(issue_q.size() + res_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
